// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit between the EX/MEM register and a
// word-addressed data memory. Loads pick a byte/halfword/word lane and extend it.
// Word stores go straight through. Byte and halfword stores are performed as a
// two-cycle read-modify-write, stalling the pipeline for one cycle.
// Optional feature macro: MEM_ALIGN_CHECK_EN (flag and suppress misaligned
// accesses; when undefined, low address bits are ignored and the access is
// aligned down).
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [31:0]           i_store_data,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic [31:0]           o_load_data,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [31:0]           o_mem_write_data,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  input  logic [31:0]           i_mem_read_data
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [31:0]           merge_word;

  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic [1:0]            off;
  logic                  req;
  logic                  misaligned;
  logic                  store;
  logic                  load;
  logic                  sub_store;
  logic [ADDR_WIDTH-1:0] aligned_address;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_ext;
  logic [31:0]           merged;

  // Request decode: size 11 is treated as a word; store takes priority over load.
  always_comb begin
    is_byte         = (i_size == 2'b00);
    is_half         = (i_size == 2'b01);
    is_word         = i_size[1];
    off             = i_address[1:0];
    req             = i_mem_read | i_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned      = req & ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
    misaligned      = 1'b0;
`endif
    store           = i_mem_write & ~misaligned;
    load            = i_mem_read & ~i_mem_write & ~misaligned;
    sub_store       = store & ~is_word;
    aligned_address = {i_address[ADDR_WIDTH-1:2], 2'b00};
  end

  // Load path: little-endian lane select followed by sign/zero extension.
  always_comb begin
    case (off)
      2'd0:    byte_lane = i_mem_read_data[7:0];
      2'd1:    byte_lane = i_mem_read_data[15:8];
      2'd2:    byte_lane = i_mem_read_data[23:16];
      default: byte_lane = i_mem_read_data[31:24];
    endcase
    half_lane = off[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
    if (is_byte) begin
      load_ext = {{24{~i_unsigned & byte_lane[7]}}, byte_lane};
    end else if (is_half) begin
      load_ext = {{16{~i_unsigned & half_lane[15]}}, half_lane};
    end else begin
      load_ext = i_mem_read_data;
    end
  end

  // Store merge: replace only the addressed lane of the captured memory word.
  always_comb begin
    merged = merge_word;
    if (is_byte) begin
      case (off)
        2'd0:    merged[7:0]   = i_store_data[7:0];
        2'd1:    merged[15:8]  = i_store_data[7:0];
        2'd2:    merged[23:16] = i_store_data[7:0];
        default: merged[31:24] = i_store_data[7:0];
      endcase
    end else if (off[1]) begin
      merged[31:16] = i_store_data[15:0];
    end else begin
      merged[15:0]  = i_store_data[15:0];
    end
  end

  // Output and next-state logic; everything is forced quiet while reset is low
  // so a reset landing mid-RMW cannot leak a stall or a write.
  always_comb begin
    state_next       = state;
    o_stall          = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_write_data = '0;
    o_load_data      = '0;
    o_mem_address    = '0;
    o_misaligned     = 1'b0;
    if (reset) begin
      o_misaligned = misaligned;
      if (state == MERGE) begin
        o_mem_write      = 1'b1;
        o_mem_write_data = merged;
        o_mem_address    = aligned_address;
        state_next       = IDLE;
      end else if (sub_store) begin
        o_mem_read    = 1'b1;
        o_stall       = 1'b1;
        o_mem_address = aligned_address;
        state_next    = MERGE;
      end else if (store) begin
        o_mem_write      = 1'b1;
        o_mem_write_data = i_store_data;
        o_mem_address    = aligned_address;
      end else if (load) begin
        o_mem_read    = 1'b1;
        o_load_data   = load_ext;
        o_mem_address = aligned_address;
      end
    end
  end

  // State register and RMW capture of the original memory word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      merge_word <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && sub_store) begin
        merge_word <= i_mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: bench for mem_access_unit with a word-addressed memory,
// a transaction-level reference model and directed plus random traffic.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic [31:0] i_store_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] o_load_data;
  logic        o_stall;
  logic        o_misaligned;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] i_mem_read_data;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_address        (i_address),
    .i_store_data     (i_store_data),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .i_size           (i_size),
    .i_unsigned       (i_unsigned),
    .o_load_data      (o_load_data),
    .o_stall          (o_stall),
    .o_misaligned     (o_misaligned),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .i_mem_read_data  (i_mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, combinational read, write at posedge.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (o_mem_write) mem[o_mem_address[7:2]] <= o_mem_write_data;
  end
  assign i_mem_read_data = o_mem_read ? mem[o_mem_address[7:2]] : 32'h0;

  // Reference memory and per-cycle expectations.
  logic [31:0] ref_mem [0:63];
  logic        chk_en = 1'b0;
  logic        e_stall, e_rd, e_wr, e_mis;
  logic [31:0] e_load, e_wdata, e_addr;

  int tests = 0;
  int fails = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (word >> (off * 8)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (word >> ((off / 2) * 16)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] old, input logic [1:0] off,
                                           input logic [1:0] sz, input logic [31:0] d);
    int unsigned sh, m;
    if (sz == 2'd0) begin
      sh = off * 8;
      m  = 32'hFF << sh;
      return (old & ~m) | ((d % 256) << sh);
    end
    sh = (off / 2) * 16;
    m  = 32'hFFFF << sh;
    return (old & ~m) | ((d % 65536) << sh);
  endfunction

  function automatic logic mis_model(input logic [1:0] off, input logic [1:0] sz);
`ifdef MEM_ALIGN_CHECK_EN
    return ((sz == 2'd1) && (off % 2 == 1)) || ((sz >= 2'd2) && (off != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_exp();
    e_stall = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_mis = 1'b0;
    e_load = '0; e_wdata = '0;
  endtask

  // Compare process: every negedge while checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("stall", {31'b0, o_stall}, {31'b0, e_stall});
      check32("mem_read", {31'b0, o_mem_read}, {31'b0, e_rd});
      check32("mem_write", {31'b0, o_mem_write}, {31'b0, e_wr});
      check32("misaligned", {31'b0, o_misaligned}, {31'b0, e_mis});
      check32("load_data", o_load_data, e_load);
      if (e_wr) check32("write_data", o_mem_write_data, e_wdata);
      if (e_rd || e_wr) check32("mem_address", o_mem_address, e_addr);
    end
  end

  // One pipeline transaction; returns at the negedge of its last cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic uns);
    logic [31:0] w;
    logic        mis;
    @(posedge clk); #1;
    i_address = a; i_store_data = d; i_mem_read = rd; i_mem_write = wr;
    i_size = sz; i_unsigned = uns;
    clear_exp();
    w      = ref_mem[a[7:2]];
    mis    = mis_model(a[1:0], sz) && (rd || wr);
    e_mis  = mis;
    e_addr = {a[31:2], 2'b00};
    chk_en = 1'b1;
    if (wr && !mis) begin
      if (sz >= 2'd2) begin
        e_wr = 1'b1; e_wdata = d; ref_mem[a[7:2]] = d;
      end else begin
        e_rd = 1'b1; e_stall = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        e_rd = 1'b0; e_stall = 1'b0; e_wr = 1'b1;
        e_wdata = st_model(w, a[1:0], sz, d);
        ref_mem[a[7:2]] = e_wdata;
      end
    end else if (rd && !mis) begin
      e_rd = 1'b1;
      e_load = ld_model(w, a[1:0], sz, uns);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    do_op(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    i_address = '0; i_store_data = '0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_size = '0; i_unsigned = 1'b0;
    clear_exp();
    e_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Fill memory through the unit so memory and model start identical.
    for (int unsigned k = 0; k < 64; k++) begin
      do_op(k * 4, $urandom(), 1'b0, 1'b1, 2'd2, 1'b0);
    end

    // Reset mid-stream: outputs quiet, then back to normal operation.
    do_op(32'h10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clk); #1;
    i_mem_read = 1'b1; reset = 1'b0;
    clear_exp();
    @(negedge clk);
    check32("reset_load_data", o_load_data, 32'h0);
    @(posedge clk); #1;
    i_mem_read = 1'b0; reset = 1'b1;
    idle();

    // Loads from 0x8899AABB.
    do_op(32'h10, 32'h8899AABB, 1'b0, 1'b1, 2'd2, 1'b0);
    do_op(32'h13, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    check32("lb_0x13", o_load_data, 32'hFFFFFF88);
    do_op(32'h13, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1);
    check32("lbu_0x13", o_load_data, 32'h00000088);
    do_op(32'h10, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0);
    check32("lh_0x10", o_load_data, 32'hFFFFAABB);
    check32("lh_no_stall", {31'b0, o_stall}, 32'h0);

    // Byte store RMW.
    do_op(32'h20, 32'h11223344, 1'b0, 1'b1, 2'd2, 1'b0);
    do_op(32'h21, 32'h0000005A, 1'b0, 1'b1, 2'd0, 1'b0);
    check32("sb_merge_data", o_mem_write_data, 32'h11225A44);
    do_op(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    check32("sb_result", o_load_data, 32'h11225A44);

    // Upper halfword store and a plain word store.
    do_op(32'h20, 32'h11223344, 1'b0, 1'b1, 2'd2, 1'b0);
    do_op(32'h22, 32'h0000BEEF, 1'b0, 1'b1, 2'd1, 1'b0);
    do_op(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    check32("sh_result", o_load_data, 32'hBEEF3344);
    do_op(32'h24, 32'hCAFEF00D, 1'b0, 1'b1, 2'd2, 1'b0);
    check32("sw_no_stall", {31'b0, o_stall}, 32'h0);
    do_op(32'h24, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    check32("sw_result", o_load_data, 32'hCAFEF00D);

    // Reset during MERGE cancels the write.
    @(posedge clk); #1;
    i_address = 32'h21; i_store_data = 32'h5A; i_mem_read = 1'b0; i_mem_write = 1'b1;
    i_size = 2'd0; i_unsigned = 1'b0;
    clear_exp(); e_addr = 32'h20; e_rd = 1'b1; e_stall = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_exp();
    @(negedge clk);
    check32("merge_reset_write", {31'b0, o_mem_write}, 32'h0);
    check32("merge_reset_stall", {31'b0, o_stall}, 32'h0);
    @(posedge clk); #1;
    i_mem_write = 1'b0; reset = 1'b1;
    idle();
    do_op(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    check32("merge_reset_mem", o_load_data, 32'hBEEF3344);

    // Misaligned word load.
    do_op(32'h22, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    check32("lw_mis_flag", {31'b0, o_misaligned}, 32'h1);
    check32("lw_mis_read", {31'b0, o_mem_read}, 32'h0);
    check32("lw_mis_data", o_load_data, 32'h0);
`else
    check32("lw_mis_flag", {31'b0, o_misaligned}, 32'h0);
    check32("lw_mis_data", o_load_data, 32'hBEEF3344);
`endif

    // Randomised traffic against the model.
    for (int unsigned n = 0; n < 400; n++) begin
      do_op($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle();

    // Final sweep: memory contents equal the model.
    chk_en = 1'b0;
    for (int unsigned k = 0; k < 64; k++) begin
      check32("final_mem", mem[k], ref_mem[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
